generador_rectangulos: RTL and testbench

Parametrised successor to the fixed-rectangle pixel generator. It holds a run-time-programmable table of `N_RECT` rectangles, each with its own colour, enable and blink attribute. The table is double-buffered so that updates take effect only at a frame boundary. The block sits between the VGA sync/scan counter and the RGB output pins and produces `graph_rgb` with a fixed 2-cycle pipeline latency.

---
 rtl/generador_pkg.sv | 32 +++
 rtl/codificador_prioridad.sv | 23 ++
 rtl/generador_rectangulos.sv | 137 +++++++++++++
 tb/tb_generador_rectangulos.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/generador_pkg.sv
// Shared types for the rectangle generator: rectangle descriptor and its hit test.
// Fields are held at maximum width; instances zero-extend narrower coordinates and colours.
package generador_pkg;

    localparam int COORD_W_DEF = 10;
    localparam int RGB_W_DEF   = 3;
    localparam int COORD_MAX_W = 16;
    localparam int RGB_MAX_W   = 12;

    typedef logic [COORD_MAX_W-1:0] coord_t;
    typedef logic [RGB_MAX_W-1:0]   color_t;

    typedef struct packed {
        coord_t x_l;
        coord_t x_r;
        coord_t y_t;
        coord_t y_b;
        color_t rgb;
        logic   en;
        logic   blink;
    } rect_t;

    localparam rect_t RECT_RESET = '0;

    // Inverted bounds (x_l > x_r or y_t > y_b) fall out as "never hits".
    function automatic logic rect_hit(input rect_t r, input coord_t x, input coord_t y,
                                      input logic phase);
        return r.en && (r.x_l <= x) && (x <= r.x_r) && (r.y_t <= y) && (y <= r.y_b)
               && !(r.blink && phase);
    endfunction

endpackage

// File: rtl/codificador_prioridad.sv
// Lowest-set-bit priority encoder, purely combinational, no backpressure.
// idx is 0 when no request bit is set.
module codificador_prioridad #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/generador_rectangulos.sv
// Programmable rectangle overlay, double-buffered table committed on frame_start; 2-cycle pixel latency.
// Writes are refused only during the frame_start cycle (and reset); the pixel stream never stalls.
module generador_rectangulos
    import generador_pkg::*;
#(
    parameter int               N_RECT       = 16,
    parameter int               COORD_W      = COORD_W_DEF,
    parameter int               RGB_W        = RGB_W_DEF,
    parameter logic [RGB_W-1:0] BG_RGB       = '0,
    parameter int               BLINK_FRAMES = 30,
    localparam int              IDX_W        = $clog2(N_RECT)
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               video_on,
    input  logic               frame_start,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x_l,
    input  logic [COORD_W-1:0] wr_x_r,
    input  logic [COORD_W-1:0] wr_y_t,
    input  logic [COORD_W-1:0] wr_y_b,
    input  logic [RGB_W-1:0]   wr_rgb,
    input  logic               wr_en,
    input  logic               wr_blink,
    output logic [RGB_W-1:0]   graph_rgb,
    output logic               hit_valid,
    output logic [IDX_W-1:0]   hit_idx
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    rect_t            pending [N_RECT];
    rect_t            active  [N_RECT];
    logic             dirty;
    logic [FC_W-1:0]  frame_cnt;
    logic             blink_phase;
    rect_t            wr_rect;
    logic             idx_ok;
    logic             wr_fire;

    assign wr_ready = !frame_start && RESET_N;
    assign idx_ok   = (32'(wr_idx) < 32'(N_RECT));
    assign wr_fire  = wr_valid && wr_ready && idx_ok;

    always_comb begin
        wr_rect       = RECT_RESET;
        wr_rect.x_l   = COORD_MAX_W'(wr_x_l);
        wr_rect.x_r   = COORD_MAX_W'(wr_x_r);
        wr_rect.y_t   = COORD_MAX_W'(wr_y_t);
        wr_rect.y_b   = COORD_MAX_W'(wr_y_b);
        wr_rect.rgb   = RGB_MAX_W'(wr_rgb);
        wr_rect.en    = wr_en;
        wr_rect.blink = wr_blink;
    end

    // Bank update, commit and blink counter all share the frame_start edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_RECT; i++) begin
                pending[i] <= RECT_RESET;
                active[i]  <= RECT_RESET;
            end
            dirty       <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (dirty) begin
                active <= pending;
                dirty  <= 1'b0;
            end
            if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end else if (wr_fire) begin
            pending[wr_idx] <= wr_rect;
            dirty           <= 1'b1;
        end
    end

    logic [N_RECT-1:0] hit_s1;
    color_t            rgb_s1 [N_RECT];
    logic              von_s1;

    // Colours travel with the hit vector so a commit cannot recolour pixels already in flight.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            hit_s1 <= '0;
            von_s1 <= 1'b0;
            for (int i = 0; i < N_RECT; i++) begin
                rgb_s1[i] <= '0;
            end
        end else begin
            von_s1 <= video_on;
            for (int i = 0; i < N_RECT; i++) begin
                hit_s1[i] <= rect_hit(active[i], COORD_MAX_W'(pix_x), COORD_MAX_W'(pix_y),
                                      blink_phase);
                rgb_s1[i] <= active[i].rgb;
            end
        end
    end

    logic [IDX_W-1:0] win_idx;
    logic             win_vld;

    codificador_prioridad #(
        .N     (N_RECT),
        .IDX_W (IDX_W)
    ) u_codificador (
        .req   (hit_s1),
        .idx   (win_idx),
        .valid (win_vld)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            graph_rgb <= '0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end else if (von_s1 && win_vld) begin
            graph_rgb <= RGB_W'(rgb_s1[win_idx]);
            hit_valid <= 1'b1;
            hit_idx   <= win_idx;
        end else begin
            graph_rgb <= von_s1 ? BG_RGB : '0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
        end
    end

endmodule

// File: tb/tb_generador_rectangulos.sv
// Bench for generador_rectangulos: directed scenarios plus random traffic against a frame-level model.
module tb_generador_rectangulos;

    localparam int             N  = 6;
    localparam int             CW = 10;
    localparam int             RW = 3;
    localparam int             BF = 2;
    localparam int             IW = $clog2(N);
    localparam logic [RW-1:0]  BG = 3'b110;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [CW-1:0] pix_x, pix_y;
    logic          video_on, frame_start, wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wr_x_l, wr_x_r, wr_y_t, wr_y_b;
    logic [RW-1:0] wr_rgb;
    logic          wr_en, wr_blink;
    logic [RW-1:0] graph_rgb;
    logic          hit_valid;
    logic [IW-1:0] hit_idx;

    generador_rectangulos #(
        .N_RECT       (N),
        .COORD_W      (CW),
        .RGB_W        (RW),
        .BG_RGB       (BG),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_x_l      (wr_x_l),
        .wr_x_r      (wr_x_r),
        .wr_y_t      (wr_y_t),
        .wr_y_b      (wr_y_b),
        .wr_rgb      (wr_rgb),
        .wr_en       (wr_en),
        .wr_blink    (wr_blink),
        .graph_rgb   (graph_rgb),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx)
    );

    typedef struct {
        int xl, xr, yt, yb, rgb;
        bit en, blink;
    } mrect_t;

    mrect_t m_pend [N];
    mrect_t m_act  [N];
    bit     m_dirty;
    int     m_fs;
    int     p_rgb, p_hv, p_hi;
    int     tests = 0;
    int     fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = '{default: 0};
            m_act[i]  = '{default: 0};
        end
        m_dirty = 1'b0;
        m_fs    = 0;
    endtask

    // Blink phase derived from frames elapsed since reset.
    task automatic model_pixel(input int x, input int y, input bit von,
                               output int rgb, output int hv, output int hi);
        bit phase;
        phase = ((m_fs / BF) % 2) == 1;
        rgb = von ? int'(BG) : 0;
        hv  = 0;
        hi  = 0;
        if (von) begin
            for (int i = 0; i < N; i++) begin
                if (hv == 0 && m_act[i].en && m_act[i].xl <= x && x <= m_act[i].xr &&
                    m_act[i].yt <= y && y <= m_act[i].yb && !(m_act[i].blink && phase)) begin
                    hv  = 1;
                    hi  = i;
                    rgb = m_act[i].rgb;
                end
            end
        end
    endtask

    task automatic step();
        int n_rgb, n_hv, n_hi;
        #1;
        check("wr_ready", 32'(wr_ready), 32'(!frame_start && rst_n));
        if (rst_n) begin
            model_pixel(int'(pix_x), int'(pix_y), video_on, n_rgb, n_hv, n_hi);
        end else begin
            n_rgb = 0; n_hv = 0; n_hi = 0;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            p_rgb = 0; p_hv = 0; p_hi = 0;
        end else if (frame_start) begin
            if (m_dirty) begin
                m_act   = m_pend;
                m_dirty = 1'b0;
            end
            m_fs++;
        end else if (wr_valid && int'(wr_idx) < N) begin
            m_pend[wr_idx].xl    = int'(wr_x_l);
            m_pend[wr_idx].xr    = int'(wr_x_r);
            m_pend[wr_idx].yt    = int'(wr_y_t);
            m_pend[wr_idx].yb    = int'(wr_y_b);
            m_pend[wr_idx].rgb   = int'(wr_rgb);
            m_pend[wr_idx].en    = wr_en;
            m_pend[wr_idx].blink = wr_blink;
            m_dirty = 1'b1;
        end
        #1;
        check("graph_rgb", 32'(graph_rgb), 32'(p_rgb));
        check("hit_valid", 32'(hit_valid), 32'(p_hv));
        check("hit_idx",   32'(hit_idx),   32'(p_hi));
        p_rgb = n_rgb; p_hv = n_hv; p_hi = n_hi;
    endtask

    task automatic pix(input int x, input int y);
        pix_x = CW'(x);
        pix_y = CW'(y);
        step();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic do_write(input int idx, input int xl, input int xr, input int yt, input int yb,
                            input int rgb, input bit en, input bit blink);
        wr_idx   = IW'(idx);
        wr_x_l   = CW'(xl);
        wr_x_r   = CW'(xr);
        wr_y_t   = CW'(yt);
        wr_y_b   = CW'(yb);
        wr_rgb   = RW'(rgb);
        wr_en    = en;
        wr_blink = blink;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; video_on = 1'b1; frame_start = 1'b0; wr_valid = 1'b0;
        pix_x = '0; pix_y = '0; wr_idx = '0;
        wr_x_l = '0; wr_x_r = '0; wr_y_t = '0; wr_y_b = '0;
        wr_rgb = '0; wr_en = 1'b0; wr_blink = 1'b0;
        model_reset();
        p_rgb = 0; p_hv = 0; p_hi = 0;
        repeat (3) step();
        rst_n = 1'b1;

        for (int x = 0; x < 20; x++) pix(x * 37, 100);

        do_write(0, 140, 151, 144, 335, 4, 1'b1, 1'b0);
        frame();
        pix(140, 144); pix(139, 144); pix(152, 144); pix(151, 335); pix(145, 336);

        do_write(0, 0, 1023, 0, 1023, 7, 1'b1, 1'b0);
        pix(140, 144); pix(500, 500);
        frame();
        pix(500, 500);

        do_write(2, 100, 200, 100, 200, 2, 1'b1, 1'b0);
        do_write(5, 150, 250, 150, 250, 1, 1'b1, 1'b0);
        do_write(3, 300, 200, 0, 1023, 5, 1'b1, 1'b0);
        do_write(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        frame();
        pix(175, 175); pix(225, 225); pix(250, 100); pix(300, 100); pix(250, 250); pix(251, 250);

        do_write(7, 0, 1023, 0, 1023, 3, 1'b1, 1'b0);
        do_write(6, 0, 1023, 0, 1023, 3, 1'b1, 1'b0);
        frame();
        pix(50, 50); pix(175, 175);

        wr_idx = IW'(1); wr_x_l = CW'(0); wr_x_r = CW'(50); wr_y_t = CW'(0); wr_y_b = CW'(50);
        wr_rgb = RW'(6); wr_en = 1'b1; wr_blink = 1'b0; wr_valid = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        wr_valid = 1'b0;
        pix(10, 10);
        frame();
        pix(10, 10);

        do_write(4, 400, 420, 400, 420, 7, 1'b1, 1'b1);
        for (int f = 0; f < 6; f++) begin
            frame();
            pix(410, 410); pix(10, 10);
            video_on = 1'b0; pix(410, 410); video_on = 1'b1;
        end

        repeat (3000) begin
            rst_n       = ($urandom_range(0, 999) != 0);
            frame_start = ($urandom_range(0, 49) == 0);
            video_on    = ($urandom_range(0, 9) != 0);
            wr_valid    = ($urandom_range(0, 4) == 0);
            wr_idx      = IW'($urandom_range(0, 7));
            wr_x_l      = CW'($urandom_range(0, 63));
            wr_x_r      = CW'($urandom_range(0, 63));
            wr_y_t      = CW'($urandom_range(0, 63));
            wr_y_b      = CW'($urandom_range(0, 63));
            wr_rgb      = RW'($urandom_range(0, 7));
            wr_en       = ($urandom_range(0, 3) != 0);
            wr_blink    = ($urandom_range(0, 3) == 0);
            pix_x       = CW'($urandom_range(0, 70));
            pix_y       = CW'($urandom_range(0, 70));
            step();
        end
        rst_n = 1'b1; frame_start = 1'b0; wr_valid = 1'b0; video_on = 1'b1;

        do_write(0, 0, 1023, 0, 1023, 5, 1'b1, 1'b0);
        frame();
        pix(10, 10); pix(11, 10);
        rst_n = 1'b0;
        pix(12, 10);
        rst_n = 1'b1;
        pix(10, 10); pix(11, 10); pix(12, 10);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
